// File: rtl/bird_motion_ctrl_if.sv
// rtl/bird_motion_ctrl_if.sv - flap/collide inputs and bird motion outputs as one bundle
// Purpose: carries the game-level signals between the stimulus side (button
//          stage + pipe logic) and bird_motion_ctrl.
// Signals: flap      - single-cycle flap pulse
//          collide   - bird cell overlaps a pipe (level)
//          bird_row  - current bird row, 0 = top
//          playing   - game is in PLAY
//          game_over - game is in DEAD
//          step      - one-cycle pulse after each executed gravity step
// Modports: master drives flap/collide, slave (the controller) drives the rest.
interface bird_motion_ctrl_if #(
    parameter int ROWS = 16
);
    logic                    flap;
    logic                    collide;
    logic [$clog2(ROWS)-1:0] bird_row;
    logic                    playing;
    logic                    game_over;
    logic                    step;

    modport master (
        output flap,
        output collide,
        input  bird_row,
        input  playing,
        input  game_over,
        input  step
    );

    modport slave (
        input  flap,
        input  collide,
        output bird_row,
        output playing,
        output game_over,
        output step
    );
endinterface

// File: rtl/bird_motion_ctrl.sv
// rtl/bird_motion_ctrl.sv - IDLE/PLAY/DEAD game controller with gravity tick and bird row
// Purpose: turns flap pulses into bird vertical motion, advancing one gravity
//          step every TICK_DIV cycles while playing; pipe collisions or
//          hitting the floor end the game.
// Ports:   clk   - system clock
//          reset - asynchronous active-high reset
//          bus   - slave side of bird_motion_ctrl_if (flap, collide in;
//                  bird_row, playing, game_over, step out)
module bird_motion_ctrl #(
    parameter int ROWS      = 16,
    parameter int START_ROW = 7,
    parameter int TICK_DIV  = 12500000,
    parameter int FLAP_RISE = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    bird_motion_ctrl_if.slave    bus
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(TICK_DIV);

    localparam logic [RW:0]   RISE_W   = (RW+1)'(FLAP_RISE);
    localparam logic [RW:0]   FLOOR_W  = (RW+1)'(ROWS - 1);
    localparam logic [RW-1:0] START_W  = RW'(START_ROW);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_DEAD
    } state_t;

    state_t        state_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] cnt_q;
    logic          pend_q;
    logic          step_q;

    // One guard bit above the row: a rise past the top shows up as the MSB
    // set, which selects the clamp to row 0.
    logic [RW:0]   rise_ext;
    logic [RW:0]   fall_ext;
    logic [RW-1:0] rise_row_d;

    assign rise_ext   = {1'b0, row_q} - RISE_W;
    assign fall_ext   = {1'b0, row_q} + {{RW{1'b0}}, 1'b1};
    assign rise_row_d = rise_ext[RW] ? '0 : rise_ext[RW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            row_q   <= START_W;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            step_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // The starting flap only launches the game; it is not a rise.
                    if (bus.flap) begin
                        state_q <= ST_PLAY;
                        cnt_q   <= '0;
                        pend_q  <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (bus.collide) begin
                        // Collision wins over a coinciding step: no move, no pulse.
                        state_q <= ST_DEAD;
                        pend_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q  <= '0;
                        step_q <= 1'b1;
                        pend_q <= 1'b0;
                        if (pend_q || bus.flap) begin
                            row_q <= rise_row_d;
                        end else if (fall_ext >= FLOOR_W) begin
                            row_q   <= FLOOR_W[RW-1:0];
                            state_q <= ST_DEAD;
                        end else begin
                            row_q <= fall_ext[RW-1:0];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (bus.flap) begin
                            pend_q <= 1'b1;
                        end
                    end
                end
                ST_DEAD: begin
                    if (bus.flap) begin
                        state_q <= ST_IDLE;
                        row_q   <= START_W;
                        cnt_q   <= '0;
                        pend_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.bird_row  = row_q;
    assign bus.playing   = (state_q == ST_PLAY);
    assign bus.game_over = (state_q == ST_DEAD);
    assign bus.step      = step_q;
endmodule

// File: tb/tb_bird_motion_ctrl.sv
// tb/tb_bird_motion_ctrl.sv - self-checking bench for bird_motion_ctrl
module tb_bird_motion_ctrl;
    localparam int ROWS      = 16;
    localparam int START_ROW = 7;
    localparam int TICK_DIV  = 4;
    localparam int FLAP_RISE = 3;

    logic clk;
    logic reset;

    bird_motion_ctrl_if #(.ROWS(ROWS)) bus ();

    bird_motion_ctrl #(
        .ROWS      (ROWS),
        .START_ROW (START_ROW),
        .TICK_DIV  (TICK_DIV),
        .FLAP_RISE (FLAP_RISE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Reference game: mode 0 = idle, 1 = playing, 2 = dead.
    // since_start counts clock edges spent in play since the last launch;
    // a gravity step happens every TICK_DIV-th of those edges.
    int m_mode;
    int m_row;
    int m_since_start;
    int m_flap_wanted;
    int m_step;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode        = 0;
        m_row         = START_ROW;
        m_since_start = 0;
        m_flap_wanted = 0;
        m_step        = 0;
    endtask

    task automatic model_edge(input int f, input int c);
        m_step = 0;
        if (m_mode == 0) begin
            if (f != 0) begin
                m_mode        = 1;
                m_since_start = 0;
                m_flap_wanted = 0;
            end
        end else if (m_mode == 1) begin
            if (c != 0) begin
                m_mode        = 2;
                m_flap_wanted = 0;
            end else begin
                m_since_start = m_since_start + 1;
                if (f != 0) m_flap_wanted = 1;
                if (m_since_start % TICK_DIV == 0) begin
                    m_step = 1;
                    if (m_flap_wanted != 0) begin
                        m_row = (m_row > FLAP_RISE) ? m_row - FLAP_RISE : 0;
                    end else begin
                        m_row = m_row + 1;
                        if (m_row == ROWS - 1) m_mode = 2;
                    end
                    m_flap_wanted = 0;
                end
            end
        end else begin
            if (f != 0) begin
                m_mode        = 0;
                m_row         = START_ROW;
                m_flap_wanted = 0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".row"},       int'(bus.bird_row),  m_row);
        check_val({tag, ".playing"},   int'(bus.playing),   (m_mode == 1) ? 1 : 0);
        check_val({tag, ".game_over"}, int'(bus.game_over), (m_mode == 2) ? 1 : 0);
        check_val({tag, ".step"},      int'(bus.step),      m_step);
    endtask

    // Called at posedge+1: apply inputs, take one edge, check one step later.
    task automatic cyc(input int f, input int c, input string tag);
        bus.flap    = (f != 0);
        bus.collide = (c != 0);
        @(posedge clk);
        model_edge(f, c);
        #1;
        check_outputs(tag);
        bus.flap    = 1'b0;
        bus.collide = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(0, 0, tag);
    endtask

    // Asynchronous reset in the middle of a clock period.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs({tag, ".async"});
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs({tag, ".held"});
    endtask

    initial begin
        int f;
        int c;
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        bus.flap    = 1'b0;
        bus.collide = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs("reset");

        // Idle with no flap: stays put, collide ignored, step silent.
        idle_cycles(10, "idle");
        cyc(0, 1, "idle_collide");
        idle_cycles(10, "idle");
        check_val("idle_row_const", int'(bus.bird_row), 7);

        // Launch and two plain falls.
        cyc(1, 0, "launch");
        check_val("launch_playing", int'(bus.playing), 1);
        check_val("launch_row", int'(bus.bird_row), 7);
        idle_cycles(4, "fall1");
        check_val("fall1_row", int'(bus.bird_row), 8);
        check_val("fall1_step", int'(bus.step), 1);
        idle_cycles(4, "fall2");
        check_val("fall2_row", int'(bus.bird_row), 9);

        // Two flaps inside one window collapse to a single rise.
        cyc(0, 0, "dbl");
        cyc(1, 0, "dbl");
        cyc(1, 0, "dbl");
        cyc(0, 0, "dbl");
        check_val("dbl_row", int'(bus.bird_row), 6);
        idle_cycles(4, "dbl_after");
        check_val("dbl_after_row", int'(bus.bird_row), 7);

        // Climb to row 1, then clamp at the top; flap on the step cycle counts.
        cyc(1, 0, "climb"); idle_cycles(3, "climb");
        check_val("climb1_row", int'(bus.bird_row), 4);
        idle_cycles(3, "climb"); cyc(1, 0, "climb");
        check_val("climb2_row", int'(bus.bird_row), 1);
        cyc(1, 0, "clamp"); idle_cycles(3, "clamp");
        check_val("clamp_row", int'(bus.bird_row), 0);

        // Free fall to the floor.
        for (int r = 1; r <= 15; r++) begin
            idle_cycles(4, "freefall");
            check_val("freefall_row", int'(bus.bird_row), r);
        end
        check_val("floor_game_over", int'(bus.game_over), 1);
        idle_cycles(12, "dead_hold");
        cyc(0, 1, "dead_collide");
        check_val("dead_row", int'(bus.bird_row), 15);

        // Restart, relaunch, first step exactly TICK_DIV edges later.
        cyc(1, 0, "restart");
        check_val("restart_row", int'(bus.bird_row), 7);
        check_val("restart_go", int'(bus.game_over), 0);
        cyc(1, 0, "relaunch");
        idle_cycles(3, "relaunch");
        check_val("relaunch_nostep", int'(bus.bird_row), 7);
        cyc(0, 0, "relaunch_step");
        check_val("relaunch_step_row", int'(bus.bird_row), 8);
        check_val("relaunch_step_pulse", int'(bus.step), 1);

        // Collide on a step cycle at row 5.
        cyc(1, 0, "to5"); idle_cycles(3, "to5");
        check_val("to5_row", int'(bus.bird_row), 5);
        idle_cycles(3, "coll");
        cyc(0, 1, "coll_step");
        check_val("coll_go", int'(bus.game_over), 1);
        check_val("coll_row", int'(bus.bird_row), 5);
        check_val("coll_step_pulse", int'(bus.step), 0);
        idle_cycles(4, "coll_after");

        // Mid-game asynchronous reset.
        cyc(1, 0, "pre_rst"); cyc(1, 0, "pre_rst"); idle_cycles(5, "pre_rst");
        async_reset("rst_mid");
        check_val("rst_mid_row", int'(bus.bird_row), 7);
        check_val("rst_mid_playing", int'(bus.playing), 0);

        // Randomized play against the reference game.
        for (int i = 0; i < 3000; i++) begin
            f = ($urandom_range(0, 5) == 0) ? 1 : 0;
            c = ($urandom_range(0, 39) == 0) ? 1 : 0;
            if ($urandom_range(0, 599) == 0) async_reset("rnd_rst");
            else cyc(f, c, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
